// File: rtl/control_unit.sv
// control_unit: multi-cycle sequencer for the 8-bit Harvard CPU.
// Fetches and decodes instructions and steps the register file, ALU and data memory.
module control_unit #(
    parameter logic [7:0] RESET_PC = 8'h00,
    localparam int unsigned DATA_W   = 8,
    localparam int unsigned REG_AW   = 2,
    localparam int unsigned ALU_OP_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    output logic [DATA_W-1:0]   imem_addr,
    input  logic [DATA_W-1:0]   imem_data,
    output logic [REG_AW-1:0]   rf_rd_addr,
    output logic [REG_AW-1:0]   rf_rr_addr,
    input  logic [DATA_W-1:0]   rf_rd_data,
    input  logic [DATA_W-1:0]   rf_rr_data,
    output logic                rf_wr_en,
    output logic [REG_AW-1:0]   rf_wr_addr,
    output logic [DATA_W-1:0]   rf_wr_data,
    output logic [ALU_OP_W-1:0] alu_op,
    input  logic [DATA_W-1:0]   alu_result,
    output logic [DATA_W-1:0]   dmem_addr,
    output logic [DATA_W-1:0]   dmem_wdata,
    output logic                dmem_we,
    input  logic [DATA_W-1:0]   dmem_rdata,
    output logic                zero_flag,
    output logic                halted
);

    localparam logic [3:0] OP_MOV  = 4'h6;
    localparam logic [3:0] OP_LDI  = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JZ   = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_IMM,
        S_EXEC,
        S_WRITE,
        S_HALT
    } state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] pc, pc_n;
    logic [DATA_W-1:0] ir, ir_n;
    logic [DATA_W-1:0] wb_data, wb_data_n;
    logic              z, z_n;
    logic [3:0]        opcode;
    logic              is_alu;
    logic [DATA_W-1:0] pc_inc;

    assign opcode = ir[7:4];
    assign is_alu = (opcode >= 4'h1) && (opcode <= 4'h5);
    assign pc_inc = pc + DATA_W'(1);

    // Address and data paths are pure wiring from the internal registers and rf data.
    assign imem_addr  = pc;
    assign rf_rd_addr = ir[3:2];
    assign rf_rr_addr = ir[1:0];
    assign rf_wr_addr = ir[3:2];
    assign rf_wr_data = wb_data;
    assign dmem_addr  = rf_rr_data;
    assign dmem_wdata = rf_rd_data;
    assign zero_flag  = z;
    assign halted     = (state == S_HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            ir      <= '0;
            wb_data <= '0;
            z       <= 1'b0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            ir      <= ir_n;
            wb_data <= wb_data_n;
            z       <= z_n;
        end
    end

    // Next-state and strobe decode; strobes derive only from registered state and ir.
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        ir_n      = ir;
        wb_data_n = wb_data;
        z_n       = z;
        rf_wr_en  = 1'b0;
        dmem_we   = 1'b0;
        alu_op    = '0;
        case (state)
            S_FETCH: begin
                ir_n    = imem_data;
                pc_n    = pc_inc;
                state_n = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_HALT:                 state_n = S_HALT;
                    4'h0, 4'hC, 4'hD, 4'hE:  state_n = S_FETCH;
                    OP_LDI, OP_JMP, OP_JZ:   state_n = S_IMM;
                    default:                 state_n = S_EXEC;
                endcase
            end
            S_IMM: begin
                state_n = S_FETCH;
                case (opcode)
                    OP_JMP: pc_n = imem_data;
                    OP_JZ:  pc_n = z ? imem_data : pc_inc;
                    OP_LDI: begin
                        wb_data_n = imem_data;
                        pc_n      = pc_inc;
                        state_n   = S_WRITE;
                    end
                    default: ;
                endcase
            end
            S_EXEC: begin
                state_n = S_WRITE;
                if (is_alu) begin
                    alu_op    = ALU_OP_W'(opcode - 4'd1);
                    wb_data_n = alu_result;
                    z_n       = (alu_result == '0);
                end else if (opcode == OP_MOV) begin
                    wb_data_n = rf_rr_data;
                end else if (opcode == OP_LD) begin
                    wb_data_n = dmem_rdata;
                end else if (opcode == OP_ST) begin
                    dmem_we = 1'b1;
                    state_n = S_FETCH;
                end else begin
                    state_n = S_FETCH;
                end
            end
            S_WRITE: begin
                rf_wr_en = 1'b1;
                state_n  = S_FETCH;
            end
            S_HALT:  state_n = S_HALT;
            default: state_n = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: random and directed programs against an instruction-level CPU model.
// Includes register-file, ALU and memory models that surround the sequencer.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] imem_addr, imem_data;
    logic [1:0] rf_rd_addr, rf_rr_addr, rf_wr_addr;
    logic [7:0] rf_rd_data, rf_rr_data, rf_wr_data;
    logic       rf_wr_en, dmem_we, zero_flag, halted;
    logic [2:0] alu_op;
    logic [7:0] alu_result, dmem_addr, dmem_wdata, dmem_rdata;

    always #5 clk = ~clk;

    control_unit #(.RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .rf_rd_addr(rf_rd_addr), .rf_rr_addr(rf_rr_addr),
        .rf_rd_data(rf_rd_data), .rf_rr_data(rf_rr_data),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .alu_op(alu_op), .alu_result(alu_result),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
        .dmem_rdata(dmem_rdata), .zero_flag(zero_flag), .halted(halted)
    );

    // Environment: imem, registered-input rf, combinational ALU, dmem
    logic [7:0] imem [256];
    logic [7:0] rf [4];
    logic [7:0] dmem [256];
    logic [7:0] rf_init [4];
    logic [7:0] dmem_init [256];
    logic       env_load;
    logic [1:0] rf_rd_q, rf_rr_q, rf_wa_q;
    logic       rf_we_q;
    logic [7:0] rf_wd_q;

    assign imem_data  = imem[imem_addr];
    assign rf_rd_data = rf[rf_rd_q];
    assign rf_rr_data = rf[rf_rr_q];
    assign dmem_rdata = dmem[dmem_addr];

    always_comb begin
        case (alu_op)
            3'd0:    alu_result = rf_rd_data + rf_rr_data;
            3'd1:    alu_result = rf_rd_data - rf_rr_data;
            3'd2:    alu_result = rf_rd_data & rf_rr_data;
            3'd3:    alu_result = rf_rd_data | rf_rr_data;
            3'd4:    alu_result = rf_rd_data ^ rf_rr_data;
            default: alu_result = 8'h00;
        endcase
    end

    always @(posedge clk) begin
        if (env_load) begin
            for (int i = 0; i < 4; i++) rf[i] <= rf_init[i];
            for (int i = 0; i < 256; i++) dmem[i] <= dmem_init[i];
            rf_we_q <= 1'b0;
            rf_rd_q <= 2'd0;
            rf_rr_q <= 2'd0;
            rf_wa_q <= 2'd0;
            rf_wd_q <= 8'h00;
        end else begin
            rf_rd_q <= rf_rd_addr;
            rf_rr_q <= rf_rr_addr;
            rf_we_q <= rf_wr_en;
            rf_wa_q <= rf_wr_addr;
            rf_wd_q <= rf_wr_data;
            if (rf_we_q) rf[rf_wa_q] <= rf_wd_q;
            if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Instruction-level reference model
    logic [7:0]  m_r [4];
    logic [7:0]  m_m [256];
    logic [7:0]  m_pc;
    logic        m_z;
    int          m_cyc;
    logic [9:0]  wr_q [$];
    logic [15:0] st_q [$];
    int          st_cnt = 0;
    logic [15:0] last_st = 16'h0;
    int          last_cyc = 0;

    function automatic logic [7:0] alu_ref(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
        case (o)
            4'h1:    return a + b;
            4'h2:    return a - b;
            4'h3:    return a & b;
            4'h4:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic model_run(input logic [7:0] start);
        logic [7:0] ins, imm;
        logic [3:0] o;
        logic [1:0] d, r;
        bit         done;
        int         n;
        for (int i = 0; i < 4; i++) m_r[i] = rf_init[i];
        for (int i = 0; i < 256; i++) m_m[i] = dmem_init[i];
        m_pc = start; m_z = 1'b0; m_cyc = 0; done = 1'b0; n = 0;
        wr_q.delete(); st_q.delete();
        while (!done && n < 500) begin
            ins = imem[m_pc];
            m_pc = m_pc + 8'd1;
            n++;
            o = ins[7:4]; d = ins[3:2]; r = ins[1:0];
            imm = imem[m_pc];
            case (o)
                4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
                    m_r[d] = alu_ref(o, m_r[d], m_r[r]);
                    m_z = (m_r[d] == 8'h00);
                    wr_q.push_back({d, m_r[d]}); m_cyc += 4;
                end
                4'h6: begin m_r[d] = m_r[r]; wr_q.push_back({d, m_r[d]}); m_cyc += 4; end
                4'h7: begin m_r[d] = imm; m_pc = m_pc + 8'd1; wr_q.push_back({d, m_r[d]}); m_cyc += 4; end
                4'h8: begin m_r[d] = m_m[m_r[r]]; wr_q.push_back({d, m_r[d]}); m_cyc += 4; end
                4'h9: begin m_m[m_r[r]] = m_r[d]; st_q.push_back({m_r[r], m_r[d]}); m_cyc += 3; end
                4'hA: begin m_pc = imm; m_cyc += 3; end
                4'hB: begin m_pc = m_z ? imm : m_pc + 8'd1; m_cyc += 3; end
                4'hF: begin done = 1'b1; m_cyc += 2; end
                default: m_cyc += 2;
            endcase
        end
    endtask

    // Per-cycle strobe scoreboard, sampled at negedge
    task automatic sample_strobes();
        if (rf_wr_en && dmem_we) check("strobe_overlap", 32'(rf_wr_en & dmem_we), 32'(0));
        if (rf_wr_en) begin
            if (wr_q.size() == 0) check("rf_wr_extra", 32'(wr_q.size()), 32'(1));
            else check("rf_wr", 32'({rf_wr_addr, rf_wr_data}), 32'(wr_q.pop_front()));
        end
        if (dmem_we) begin
            st_cnt++;
            last_st = {dmem_addr, dmem_wdata};
            if (st_q.size() == 0) check("st_extra", 32'(st_q.size()), 32'(1));
            else check("st", 32'(last_st), 32'(st_q.pop_front()));
        end
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            sample_strobes();
        end
    endtask

    task automatic clear_env();
        for (int i = 0; i < 256; i++) begin imem[i] = 8'hF0; dmem_init[i] = 8'h00; end
        for (int i = 0; i < 4; i++) rf_init[i] = 8'h00;
        wr_q.delete(); st_q.delete();
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] v);
        imem[a] = v;
    endtask

    task automatic reset_and_load(input bit chk);
        rst = 1'b1; env_load = 1'b1;
        @(posedge clk); #1 env_load = 1'b0;
        @(negedge clk);
        if (chk) begin
            check("rst_imem_addr", 32'(imem_addr), 32'(8'h00));
            check("rst_rd_addr", 32'(rf_rd_addr), 32'(0));
            check("rst_rr_addr", 32'(rf_rr_addr), 32'(0));
            check("rst_wr_addr", 32'(rf_wr_addr), 32'(0));
            check("rst_wr_data", 32'(rf_wr_data), 32'(0));
            check("rst_wr_en", 32'(rf_wr_en), 32'(0));
            check("rst_dmem_we", 32'(dmem_we), 32'(0));
            check("rst_alu_op", 32'(alu_op), 32'(0));
            check("rst_halted", 32'(halted), 32'(0));
            check("rst_zero", 32'(zero_flag), 32'(0));
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic run_prog(input string tag);
        int  cyc, nbad;
        bit  done;
        model_run(8'h00);
        reset_and_load(1'b0);
        cyc = 0; done = 1'b0;
        while (!done && cyc < 3000) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            sample_strobes();
            if (halted) done = 1'b1;
        end
        if (!done) check({tag, "_timeout"}, 32'(halted), 32'(1));
        last_cyc = cyc;
        check({tag, "_cycles"}, 32'(cyc), 32'(m_cyc));
        check({tag, "_pc"}, 32'(imem_addr), 32'(m_pc));
        check({tag, "_z"}, 32'(zero_flag), 32'(m_z));
        for (int i = 0; i < 4; i++) check({tag, $sformatf("_r%0d", i)}, 32'(rf[i]), 32'(m_r[i]));
        nbad = 0;
        for (int i = 0; i < 256; i++) if (dmem[i] !== m_m[i]) nbad++;
        check({tag, "_dmem_bad"}, 32'(nbad), 32'(0));
        check({tag, "_wr_left"}, 32'(wr_q.size()), 32'(0));
        check({tag, "_st_left"}, 32'(st_q.size()), 32'(0));
    endtask

    task automatic gen_random();
        logic [7:0] op [32];
        logic [7:0] addr [33];
        logic [7:0] a;
        logic [3:0] o;
        int         n;
        clear_env();
        n = int'($urandom_range(6, 24));
        a = 8'h00;
        for (int i = 0; i < n; i++) begin
            o = 4'($urandom_range(0, 14));
            op[i] = {o, 4'($urandom_range(0, 15))};
            addr[i] = a;
            a = a + ((o == 4'h7 || o == 4'hA || o == 4'hB) ? 8'd2 : 8'd1);
        end
        addr[n] = a;
        for (int i = 0; i < n; i++) begin
            o = op[i][7:4];
            imem[addr[i]] = op[i];
            if (o == 4'h7) imem[addr[i] + 8'd1] = 8'($urandom);
            else if (o == 4'hA || o == 4'hB)
                imem[addr[i] + 8'd1] = addr[$urandom_range(32'(i + 1), 32'(n))];
        end
        for (int i = 0; i < 4; i++) rf_init[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) dmem_init[i] = 8'($urandom);
    endtask

    initial begin
        int st0;
        rst = 1'b1; env_load = 1'b0;

        // LDI R1,5; LDI R2,3; ADD R1,R2; HALT
        clear_env();
        load(8'h00, 8'h74); load(8'h01, 8'h05); load(8'h02, 8'h78);
        load(8'h03, 8'h03); load(8'h04, 8'h16); load(8'h05, 8'hF0);
        model_run(8'h00);
        reset_and_load(1'b1);
        run_prog("t1");
        check("t1_cyc14", 32'(last_cyc), 32'(14));
        check("t1_pc6", 32'(imem_addr), 32'(8'h06));
        check("t1_r1", 32'(rf[1]), 32'(8'h08));
        check("t1_z", 32'(zero_flag), 32'(0));
        run_cycles(3);
        check("t1_halt_hold", 32'(halted), 32'(1));

        // SUB to zero then taken JZ
        clear_env();
        load(8'h00, 8'h70); load(8'h01, 8'h07); load(8'h02, 8'h64);
        load(8'h03, 8'h24); load(8'h04, 8'hB0); load(8'h05, 8'h20);
        load(8'h06, 8'h00); load(8'h07, 8'hF0);
        run_prog("t2");
        check("t2_pc", 32'(imem_addr), 32'(8'h21));
        check("t2_z", 32'(zero_flag), 32'(1));

        // SUB to 0xF9 then JZ not taken
        clear_env();
        load(8'h00, 8'h70); load(8'h01, 8'h07); load(8'h02, 8'h68); load(8'h03, 8'h01);
        load(8'h04, 8'h24); load(8'h05, 8'hB0); load(8'h06, 8'h10);
        load(8'h07, 8'hF0); load(8'h10, 8'h00);
        run_prog("t3");
        check("t3_r1", 32'(rf[1]), 32'(8'hF9));
        check("t3_z", 32'(zero_flag), 32'(0));
        check("t3_pc", 32'(imem_addr), 32'(8'h08));

        // ST then LD round trip
        clear_env();
        load(8'h00, 8'h74); load(8'h01, 8'h5A); load(8'h02, 8'h78); load(8'h03, 8'h10);
        load(8'h04, 8'h96); load(8'h05, 8'h8E); load(8'h06, 8'hF0);
        st0 = st_cnt;
        run_prog("t4");
        check("t4_st_count", 32'(st_cnt - st0), 32'(1));
        check("t4_st_addr_data", 32'(last_st), 32'(16'h105A));
        check("t4_r3", 32'(rf[3]), 32'(8'h5A));
        check("t4_dmem10", 32'(dmem[8'h10]), 32'(8'h5A));
        check("t4_cyc", 32'(last_cyc), 32'(17));

        // JMP 0xFF, NOP at 0xFF wraps to 0x00
        clear_env();
        load(8'h00, 8'hA0); load(8'h01, 8'hFF); load(8'hFF, 8'h00);
        reset_and_load(1'b0);
        run_cycles(3);
        check("t5_jmp_ff", 32'(imem_addr), 32'(8'hFF));
        run_cycles(2);
        check("t5_wrap", 32'(imem_addr), 32'(8'h00));
        run_cycles(3);
        check("t5_jmp_again", 32'(imem_addr), 32'(8'hFF));

        // LDI whose immediate sits at 0xFF
        clear_env();
        load(8'h00, 8'hA0); load(8'h01, 8'hFE); load(8'hFE, 8'h74); load(8'hFF, 8'h33);
        wr_q.push_back({2'd1, 8'h33});
        reset_and_load(1'b0);
        run_cycles(3);
        check("t5_ldi_at", 32'(imem_addr), 32'(8'hFE));
        run_cycles(4);
        check("t5_ldi_wrap", 32'(imem_addr), 32'(8'h00));
        check("t5_ldi_wr_done", 32'(wr_q.size()), 32'(0));
        run_cycles(1);
        check("t5_ldi_r1", 32'(rf[1]), 32'(8'h33));

        // Undefined opcodes are 2-cycle NOPs
        clear_env();
        load(8'h00, 8'hC0); load(8'h01, 8'hD5); load(8'h02, 8'hEA); load(8'h03, 8'hF0);
        st0 = st_cnt;
        run_prog("t5u");
        check("t5u_cyc", 32'(last_cyc), 32'(8));
        check("t5u_pc", 32'(imem_addr), 32'(8'h04));
        check("t5u_no_st", 32'(st_cnt - st0), 32'(0));

        // Reset asserted during the WRITE cycle of ADD
        clear_env();
        load(8'h00, 8'h74); load(8'h01, 8'h05); load(8'h02, 8'h78);
        load(8'h03, 8'h03); load(8'h04, 8'h16); load(8'h05, 8'hF0);
        model_run(8'h00);
        reset_and_load(1'b0);
        run_cycles(11);
        check("t6_wr_en_before", 32'(rf_wr_en), 32'(1));
        #1 rst = 1'b1;
        #1;
        check("t6_wr_en_drop", 32'(rf_wr_en), 32'(0));
        check("t6_pc_reset", 32'(imem_addr), 32'(8'h00));
        check("t6_halted", 32'(halted), 32'(0));
        run_prog("t6");
        check("t6_cyc", 32'(last_cyc), 32'(14));
        check("t6_r1", 32'(rf[1]), 32'(8'h08));

        for (int k = 0; k < 30; k++) begin
            gen_random();
            run_prog($sformatf("rnd%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle sequencer for the 8-bit Harvard CPU. It fetches 8-bit instructions from instruction memory, decodes them, and sequences the register file, ALU and data memory through a fixed FSM. It drives all register-file address and write controls. Its state ordering absorbs the register file's one-cycle registered-input latency, so no hazard logic is needed.

## Interface
- RESET_PC, 8'h00, PC value loaded on reset
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- imem_addr  out  8  instruction address (= pc)
- imem_data  in  8  instruction byte, combinational read of imem_addr
- rf_rd_addr / rf_rr_addr  out  2 each  = ir[3:2] / ir[1:0]
- rf_rd_data / rf_rr_data  in  8 each  register file read data
- rf_wr_en  out  1  register write request
- rf_wr_addr  out  2  = ir[3:2]
- rf_wr_data  out  8  = wb_data
- alu_op  out  3  ADD=0, SUB=1, AND=2, OR=3, XOR=4; ALU operands are wired externally from rf_rd_data and rf_rr_data
- alu_result  in  8  combinational ALU result
- dmem_addr  out  8  = rf_rr_data
- dmem_wdata  out  8  = rf_rd_data
- dmem_we  out  1  data memory write strobe
- dmem_rdata  in  8  combinational data memory read
- zero_flag  out  1  Z flag
- halted  out  1  high in HALT state

## Operation
- Instruction format: [7:4] opcode, [3:2] rd, [1:0] rr.
  - 0x0 NOP
  - 0x1-0x5 ADD/SUB/AND/OR/XOR: rd <= rd op rr, updates Z
  - 0x6 MOV: rd <= rr
  - 0x7 LDI: rd <= next byte
  - 0x8 LD: rd <= dmem[rr]
  - 0x9 ST: dmem[rr] <= rd
  - 0xA JMP: pc <= next byte
  - 0xB JZ: pc <= next byte if Z, else skip the byte
  - 0xF HALT
  - 0xC-0xE: undefined, executed as NOP
- Internal registers: pc[7:0], ir[7:0], wb_data[7:0], Z, state.
- FSM states and transitions:
  - FETCH: ir <= imem_data, pc <= pc+1, go to DECODE.
  - DECODE: HALT goes to HALT. NOP or undefined goes to FETCH. LDI/JMP/JZ go to IMM. All other opcodes go to EXEC.
  - IMM: imem_addr = pc.
    - JMP: pc <= imem_data.
    - JZ: pc <= Z ? imem_data : pc+1.
    - LDI: wb_data <= imem_data, pc <= pc+1, go to WRITE.
    - JMP and JZ go to FETCH.
  - EXEC:
    - ALU ops: alu_op = opcode-1, wb_data <= alu_result, Z <= (alu_result==0).
    - MOV: wb_data <= rf_rr_data.
    - LD: wb_data <= dmem_rdata.
    - ALU ops, MOV and LD go to WRITE.
    - ST: dmem_we = 1, go to FETCH.
  - WRITE: rf_wr_en = 1, go to FETCH.
  - HALT: terminal; only rst exits.
- alu_op is 0 outside EXEC of ALU ops.
- Z changes only in EXEC of ALU ops.
- MOV, LDI and LD do not affect Z.
- pc arithmetic is mod 256: 0xFF+1 = 0x00, including the immediate fetch at 0xFF.

## Timing
- Controls are decoded combinationally from state and ir. They are glitch-free at clock edges. Sequential state is updated only on rising clk.
- The rf registers its addresses at the end of DECODE, so rf_rd_data and rf_rr_data are valid throughout EXEC.
- A write asserted in WRITE lands in the rf at the end of the following FETCH. The next instruction reads it at the end of its DECODE, so back-to-back dependent instructions are safe.
- rf_wr_en and dmem_we are each high for exactly one cycle per instruction that uses them. Both are never high together.
- Cycles per instruction:
  - NOP / undefined: 2
  - JMP, JZ, ST: 3
  - ALU ops, MOV, LD, LDI: 4
  - HALT: 2, then halted stays high indefinitely
- Reset values, applied immediately while rst is high:
  - state = FETCH; pc = RESET_PC; ir = 0; wb_data = 0; Z = 0
  - imem_addr = RESET_PC; rf_rd_addr = rf_rr_addr = rf_wr_addr = 0; rf_wr_data = 0
  - rf_wr_en = 0; dmem_we = 0; alu_op = 0; halted = 0; zero_flag = 0
  - dmem_addr and dmem_wdata follow rf data.
- Reset mid-instruction abandons the instruction. A strobe active at rst assertion drops asynchronously.
- The first fetch occurs in the first cycle after rst deasserts.

## Test plan
- Program 74 05 78 03 16 F0:
  - R1 = 0x08 in the rf, zero_flag = 0.
  - halted rises 14 cycles after reset release, with pc = 0x06.
- Program 70 07 64 24 B0 20 at RESET_PC = 0: SUB sets zero_flag = 1, JZ is taken, and the next imem_addr is 0x20.
- Same program with 70 07 replaced by 70 07 68 01 and 64 24 replaced by 24 B0 10 (SUB R1,R0 with R1 = 0, R0 = 7):
  - result is 0xF9, Z = 0.
  - JZ is not taken; pc continues past the immediate byte.
- With R1 = 0x5A and R2 = 0x10, execute ST 96 then LD 8E:
  - dmem_we is high one cycle with dmem_addr = 0x10 and dmem_wdata = 0x5A.
  - R3 reads 0x5A afterwards.
- JMP 0xFF with a NOP at 0xFF: pc wraps to 0x00 and fetch resumes at 0x00. Opcodes 0xC0-0xE0 each take 2 cycles with no strobes.
- Assert rst during the WRITE cycle of ADD:
  - rf_wr_en falls in the same cycle, pc = RESET_PC, state = FETCH.
  - The program restarts cleanly after release.
